// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the parametrised MEM stage.
// Pure functions only: no state, no latency.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << lo;
      SZ_HALF: lane_en = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // Sub-word store data is replicated so every enabled lane sees the right byte.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_lanes = {4{d[7:0]}};
      SZ_HALF: store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Byte-lane data RAM: synchronous byte-enabled write, combinational read.
// Write lands at the clock edge; a read in the following cycle sees it.
module mem_stage_dmem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [3:0][7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][b] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage_param.sv
// MEM stage: byte/half/word load/store with extension, fault flagging and ALU bypass.
// Latency 1 (READ_LAT cycles for loads); MEMStall holds upstream while a slow load is in flight.
module mem_stage_param
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RD_W     = 5,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              EXRegWrite,
  input  logic              EXMemRead,
  input  logic              EXMemWrite,
  input  logic [1:0]        EXMemSize,
  input  logic              EXMemUnsigned,
  input  logic [RD_W-1:0]   EXRd,
  input  logic [DATA_W-1:0] EXData,
  input  logic [DATA_W-1:0] EXALUData,
  output logic [RD_W-1:0]   MEMRd,
  output logic [DATA_W-1:0] MEMData,
  output logic              MEMRegWrite,
  output logic              MEMStall,
  output logic              MEMFault
);

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_t            state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] widx, widx_q, raddr;
  logic [1:0]        lo, lo_q, size_q;
  logic              uns_q, rw_q;
  logic [RD_W-1:0]   rd_q;
  logic              is_mem, fault, we;
  logic [3:0]        be;
  logic [31:0]       wdata, rdata;
  logic              unused_hi;

  assign widx      = EXALUData[ADDR_W+1:2];
  assign lo        = EXALUData[1:0];
  assign unused_hi = ^EXALUData[DATA_W-1:ADDR_W+2];

  assign is_mem = EXMemRead | EXMemWrite;
  assign fault  = is_mem && ((EXMemSize == SZ_RSVD) ||
                             (EXMemSize == SZ_HALF && lo[0]) ||
                             (EXMemSize == SZ_WORD && lo != 2'b00) ||
                             (EXMemRead && EXMemWrite));

  assign we    = (state == ST_IDLE) && EXMemWrite && !fault;
  assign be    = lane_en(EXMemSize, lo);
  assign wdata = store_lanes(EXMemSize, EXData);
  // A slow load re-reads its latched word at the expiry edge, not whatever EX now shows.
  assign raddr = (state == ST_WAIT) ? widx_q : widx;

  mem_stage_dmem #(.ADDR_W(ADDR_W)) u_dmem (
    .clk   (Clk),
    .we    (we),
    .waddr (widx),
    .be    (be),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      widx_q      <= '0;
      lo_q        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rw_q        <= 1'b0;
      rd_q        <= '0;
      MEMRd       <= '0;
      MEMData     <= '0;
      MEMRegWrite <= 1'b0;
      MEMStall    <= 1'b0;
      MEMFault    <= 1'b0;
    end else begin
      MEMFault <= 1'b0;
      case (state)
        ST_IDLE: begin
          MEMRd <= EXRd;
          if (fault) begin
            MEMData     <= '0;
            MEMRegWrite <= 1'b0;
            MEMFault    <= 1'b1;
          end else if (EXMemWrite) begin
            MEMData     <= '0;
            MEMRegWrite <= 1'b0;
          end else if (EXMemRead && READ_LAT > 1) begin
            MEMData     <= '0;
            MEMRegWrite <= 1'b0;
            MEMStall    <= 1'b1;
            cnt         <= LAT_M1;
            widx_q      <= widx;
            lo_q        <= lo;
            size_q      <= EXMemSize;
            uns_q       <= EXMemUnsigned;
            rw_q        <= EXRegWrite;
            rd_q        <= EXRd;
            state       <= ST_WAIT;
          end else if (EXMemRead) begin
            MEMData     <= load_ext(rdata, EXMemSize, lo, EXMemUnsigned);
            MEMRegWrite <= EXRegWrite;
          end else begin
            MEMData     <= EXALUData;
            MEMRegWrite <= EXRegWrite;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd1) begin
            MEMData     <= load_ext(rdata, size_q, lo_q, uns_q);
            MEMRd       <= rd_q;
            MEMRegWrite <= rw_q;
            MEMStall    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param at READ_LAT=1 and READ_LAT=3 against a byte-array model.
module tb_mem_stage_param;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  sz;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [31:0] a;
  } op_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        stall;
    logic        fault;
  } out_t;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  logic chk_en = 1'b0;
  op_t  in0, in1;
  int   checks = 0;
  int   failures = 0;

  logic [4:0]  m0_rd, m1_rd;
  logic [31:0] m0_data, m1_data;
  logic        m0_we, m1_we, m0_stall, m1_stall, m0_fault, m1_fault;

  always #5 Clk = ~Clk;

  mem_stage_param #(.DATA_W(32), .ADDR_W(10), .RD_W(5), .READ_LAT(1)) u0 (
    .Clk(Clk), .ResetN(ResetN),
    .EXRegWrite(in0.rw), .EXMemRead(in0.mr), .EXMemWrite(in0.mw), .EXMemSize(in0.sz),
    .EXMemUnsigned(in0.uns), .EXRd(in0.rd), .EXData(in0.d), .EXALUData(in0.a),
    .MEMRd(m0_rd), .MEMData(m0_data), .MEMRegWrite(m0_we), .MEMStall(m0_stall), .MEMFault(m0_fault)
  );

  mem_stage_param #(.DATA_W(32), .ADDR_W(10), .RD_W(5), .READ_LAT(3)) u3 (
    .Clk(Clk), .ResetN(ResetN),
    .EXRegWrite(in1.rw), .EXMemRead(in1.mr), .EXMemWrite(in1.mw), .EXMemSize(in1.sz),
    .EXMemUnsigned(in1.uns), .EXRd(in1.rd), .EXData(in1.d), .EXALUData(in1.a),
    .MEMRd(m1_rd), .MEMData(m1_data), .MEMRegWrite(m1_we), .MEMStall(m1_stall), .MEMFault(m1_fault)
  );

  // ---------------- model: byte-addressed memory, 4096 bytes per instance ----------------
  logic [7:0] mb [2][4096];
  out_t exp_o [2];
  logic exp_dv [2];
  int   busy [2];
  op_t  pend [2];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mload(input int k, input op_t x);
    int a;
    int n;
    logic [31:0] v;
    a = int'(x.a[11:0]);
    n = nbytes(x.sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[k][(a + i) % 4096]) << (8 * i));
    if (!x.uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mstore(input int k, input op_t x);
    int a;
    a = int'(x.a[11:0]);
    for (int i = 0; i < nbytes(x.sz); i++) mb[k][(a + i) % 4096] = x.d[8*i +: 8];
  endtask

  task automatic model_edge(input int k, input op_t x);
    logic flt;
    int lat;
    lat = (k == 0) ? 1 : 3;
    if (busy[k] > 0) begin
      busy[k]--;
      if (busy[k] == 0) begin
        exp_o[k].rd    = pend[k].rd;
        exp_o[k].data  = mload(k, pend[k]);
        exp_o[k].we    = pend[k].rw;
        exp_o[k].stall = 1'b0;
        exp_dv[k]      = 1'b1;
      end
      return;
    end
    flt = (x.mr || x.mw) && (x.sz == 2'd3 || (x.sz == 2'd1 && x.a[0]) ||
                             (x.sz == 2'd2 && x.a[1:0] != 2'd0) || (x.mr && x.mw));
    exp_o[k].rd    = x.rd;
    exp_o[k].stall = 1'b0;
    exp_o[k].fault = flt;
    exp_dv[k]      = 1'b1;
    if (flt || x.mw) begin
      if (!flt) mstore(k, x);
      exp_o[k].data = 32'd0;
      exp_o[k].we   = 1'b0;
    end else if (x.mr && lat > 1) begin
      busy[k]        = lat - 1;
      pend[k]        = x;
      exp_o[k].we    = 1'b0;
      exp_o[k].stall = 1'b1;
      exp_dv[k]      = 1'b0;
    end else if (x.mr) begin
      exp_o[k].data = mload(k, x);
      exp_o[k].we   = x.rw;
    end else begin
      exp_o[k].data = x.a;
      exp_o[k].we   = x.rw;
    end
  endtask

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int k = 0; k < 2; k++) begin
        exp_o[k]  = '0;
        exp_dv[k] = 1'b1;
        busy[k]   = 0;
      end
    end else begin
      model_edge(0, in0);
      model_edge(1, in1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Per-cycle compare; Rd only matters with a write, data only where it is defined.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("u0.we",    32'(m0_we),    32'(exp_o[0].we));
      chk("u0.stall", 32'(m0_stall), 32'(exp_o[0].stall));
      chk("u0.fault", 32'(m0_fault), 32'(exp_o[0].fault));
      if (exp_dv[0]) chk("u0.data", m0_data, exp_o[0].data);
      if (exp_o[0].we) chk("u0.rd", 32'(m0_rd), 32'(exp_o[0].rd));
      chk("u3.we",    32'(m1_we),    32'(exp_o[1].we));
      chk("u3.stall", 32'(m1_stall), 32'(exp_o[1].stall));
      chk("u3.fault", 32'(m1_fault), 32'(exp_o[1].fault));
      if (exp_dv[1]) chk("u3.data", m1_data, exp_o[1].data);
      if (exp_o[1].we) chk("u3.rd", 32'(m1_rd), 32'(exp_o[1].rd));
    end
  end

  // ---------------- stimulus ----------------
  function automatic op_t mk(input logic rw, input logic mr, input logic mw, input logic [1:0] sz,
                             input logic uns, input logic [4:0] rd, input logic [31:0] d,
                             input logic [31:0] a);
    op_t x;
    x = '{rw: rw, mr: mr, mw: mw, sz: sz, uns: uns, rd: rd, d: d, a: a};
    return x;
  endfunction

  task automatic op0(input op_t x);
    in0 = x;
    @(posedge Clk);
    #1;
    in0 = '0;
  endtask

  // Slow load: inputs held through the stall, outputs pinned every cycle.
  task automatic load3(input string nm, input op_t x, input logic [31:0] expd);
    in1 = x;
    @(posedge Clk); #1;
    chk({nm, ".stall1"}, 32'(m1_stall), 32'd1);
    chk({nm, ".bub1"},   32'(m1_we),    32'd0);
    @(posedge Clk); #1;
    chk({nm, ".stall2"}, 32'(m1_stall), 32'd1);
    chk({nm, ".bub2"},   32'(m1_we),    32'd0);
    @(posedge Clk); #1;
    in1 = '0;
    chk({nm, ".stall0"}, 32'(m1_stall), 32'd0);
    chk({nm, ".we"},     32'(m1_we),    32'(x.rw));
    chk({nm, ".data"},   m1_data,       expd);
    chk({nm, ".rd"},     32'(m1_rd),    32'(x.rd));
  endtask

  initial begin
    in0 = '0;
    in1 = '0;
    @(posedge Clk); #1;
    chk_en = 1'b1;
    chk("rst.data",  m0_data,         32'd0);
    chk("rst.we",    32'(m0_we),      32'd0);
    chk("rst.stall", 32'(m1_stall),   32'd0);
    chk("rst.fault", 32'(m0_fault),   32'd0);
    #1 ResetN = 1'b1;
    @(posedge Clk); #1;

    // word store then load
    op0(mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'hBEEF_BEEF, 32'd4));
    chk("sw.we", 32'(m0_we), 32'd0);
    chk("sw.data", m0_data, 32'd0);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd3, 32'd0, 32'd4));
    chk("lw4.data", m0_data, 32'hBEEF_BEEF);
    chk("lw4.we", 32'(m0_we), 32'd1);
    chk("lw4.rd", 32'(m0_rd), 32'd3);

    // byte store into a cleared word, signed / unsigned byte and full-word reads
    op0(mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'd0, 32'd4));
    op0(mk(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0000_0080, 32'd5));
    op0(mk(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 5'd2, 32'd0, 32'd5));
    chk("lb5", m0_data, 32'hFFFF_FF80);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 5'd2, 32'd0, 32'd5));
    chk("lbu5", m0_data, 32'h0000_0080);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd2, 32'd0, 32'd4));
    chk("lw4.sb", m0_data, 32'h0000_8000);

    // bypass
    op0(mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 32'd0, 32'hB00B_B00B));
    chk("byp.data", m0_data, 32'hB00B_B00B);
    chk("byp.rd", 32'(m0_rd), 32'd7);

    // upper half loads, then faults leave memory untouched
    op0(mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'h8001_0000, 32'd4));
    op0(mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 5'd4, 32'd0, 32'd6));
    chk("lh6", m0_data, 32'hFFFF_8001);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 5'd4, 32'd0, 32'd6));
    chk("lhu6", m0_data, 32'h0000_8001);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 32'd0, 32'd6));
    chk("lw6.fault", 32'(m0_fault), 32'd1);
    chk("lw6.we", 32'(m0_we), 32'd0);
    chk("lw6.data", m0_data, 32'd0);
    op0(mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0));
    chk("fault.pulse", 32'(m0_fault), 32'd0);
    op0(mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'hDEAD_DEAD, 32'd6));
    chk("sw6.fault", 32'(m0_fault), 32'd1);
    op0(mk(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0, 32'h0000_1234, 32'd5));
    chk("sh5.fault", 32'(m0_fault), 32'd1);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 5'd1, 32'd0, 32'd4));
    chk("rsvd.fault", 32'(m0_fault), 32'd1);
    op0(mk(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 5'd1, 32'h5555_5555, 32'd4));
    chk("rdwr.fault", 32'(m0_fault), 32'd1);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd1, 32'd0, 32'd4));
    chk("lw4.kept", m0_data, 32'h8001_0000);

    // address wrap: 0x1004 aliases word 1
    op0(mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'h1234_5678, 32'h0000_1004));
    op0(mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd5, 32'd0, 32'd4));
    chk("alias.lw", m0_data, 32'h1234_5678);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 5'd5, 32'd0, 32'd7));
    chk("alias.lb7", m0_data, 32'h0000_0012);
    op0(mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 5'd5, 32'd0, 32'h0000_1004));
    chk("alias.lhu", m0_data, 32'h0000_5678);

    // READ_LAT=3 instance
    in1 = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 32'hCAFE_F00D, 32'd4);
    @(posedge Clk); #1;
    in1 = '0;
    chk("l3.sw.stall", 32'(m1_stall), 32'd0);
    load3("l3.lw", mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 32'd0, 32'd4), 32'hCAFE_F00D);
    load3("l3.lb7", mk(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 5'd10, 32'd0, 32'd7), 32'hFFFF_FFCA);

    // reset while waiting aborts the load
    in1 = mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 32'd0, 32'd4);
    @(posedge Clk); #1;
    chk("abort.stall", 32'(m1_stall), 32'd1);
    #1;
    ResetN = 1'b0;
    in1 = '0;
    #1;
    chk("abort.data",  m1_data,          32'd0);
    chk("abort.we",    32'(m1_we),       32'd0);
    chk("abort.stall0", 32'(m1_stall),   32'd0);
    chk("abort.rd",    32'(m1_rd),       32'd0);
    chk("abort.fault", 32'(m1_fault),    32'd0);
    @(posedge Clk); #2;
    ResetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("abort.nowr", 32'(m1_we), 32'd0);
    end
    load3("l3.after", mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 5'd11, 32'd0, 32'd6), 32'h0000_CAFE);

    repeat (2) @(posedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
